nand_async_seq: RTL
===================

// Module: nand_async_seq
// PURPOSE
//  Upstream of the NAND PHY: turns byte-level requests (CMD/ADDR/WR/RD) into asynchronous-mode
//  (SDR) pin sequences on the PHY's controller-facing inputs.
//  Generates CLE/ALE/CE#/WE#/RE# with programmable setup/pulse/hold; captures read bytes from the PHY.
//  Sits between the command scheduler and the PHY; one NAND channel, 8 targets.
// PARAMETERS
//  T_SETUP   3  clk0 cycles CLE/ALE/DQ valid before WE#/RE# falls (min 1)
//  T_PULSE   4  clk0 cycles WE#/RE# held low (min 1)
//  T_HOLD    2  clk0 cycles after WE#/RE# rises before next op (min 1)
//  RD_LAT    3  cycles from RE# low to rd_data_comb valid (PHY regs + pad + tREA); must be <= T_PULSE
//  CNT_W     4  timer counter width; all T_* and RD_LAT < 2**CNT_W
// PORTS
//  clk0          in   1  system clock (PHY clk0 domain)
//  rst0          in   1  synchronous, active-high reset
//  req_valid     in   1  request present
//  req_ready     out  1  accept; transfer when req_valid&req_ready
//  req_op        in   2  0=CMD 1=ADDR 2=WR 3=RD (nand_pkg)
//  req_data      in   8  command/address/write byte (ignored for RD)
//  req_ce        in   3  target index -> one-hot-low ctrl_cen
//  req_last      in   1  deassert CE# after this op completes
//  rsp_valid     out  1  one-cycle pulse, read byte valid
//  rsp_data      out  8  read byte
//  busy          out  1  not IDLE or CE# asserted
//  wp_en         in   1  write-protect request (ctrl_wpn = ~wp_en, registered)
//  ctrl_cle/ctrl_ale/ctrl_wrn/ctrl_wpn  out 1 each  to PHY command registers (ctrl_wrn = RE#)
//  ctrl_cen      out  8  CE#, active low
//  ctrl_wen      out  1  WE#; ctrl_wen_sel out 1, constant 1 (async WE# mode)
//  dq_oe_n       out  1  DQ output enable, active low
//  wr_data_rise/wr_data_fall  out 8 each  same byte on both (SDR)
//  rd_data_comb  in   8  PHY combinational read byte
//  ctrl_debug0   out 16  debug bus (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: cle=0 ale=0 wrn=1 wen=1 wen_sel=1 wpn=1 cen=8'hFF dq_oe_n=1 wr_data=0
//   req_ready=0 (during rst0) rsp_valid=0 rsp_data=0 busy=0 ctrl_debug0=0
//  All outputs registered. States: IDLE, SETUP, PULSE, HOLD.
//  IDLE: req_ready=1. On accept: latch op/data/ce/last; cen[ce]=0; CMD->cle=1; ADDR->ale=1;
//   CMD/ADDR/WR->dq_oe_n=0, wr_data=req_data; RD->dq_oe_n=1. Timer=T_SETUP -> SETUP.
//  SETUP: timer expiry -> WE# low (RD: RE# low), timer=T_PULSE -> PULSE.
//  PULSE: RD samples rd_data_comb exactly RD_LAT cycles after RE# low into rsp_data;
//   rsp_valid pulses on the same cycle. Expiry -> WE#/RE# high, timer=T_HOLD -> HOLD.
//  HOLD: expiry -> cle=ale=0, dq_oe_n=1; if last then cen=8'hFF; -> IDLE.
//  req_ready=0 outside IDLE: one op per T_SETUP+T_PULSE+T_HOLD+1 cycles.
//  Not last: CE# stays low into next op; new req_ce differing from held ce: CE# switches at accept.
//  wpn follows ~wp_en with 1-cycle latency in any state; wen_sel never changes.
//  rst0 mid-op: next cycle all outputs at reset values, state IDLE, no rsp_valid.
// CONFIGURATION
//  NAND_ASYNC_SEQ_DEBUG_EN defined: ctrl_debug0 = {state[1:0], op[1:0], timer[3:0], data byte}.
//  Undefined: ctrl_debug0 tied 16'h0000, no extra logic.
// STRUCTURE
//  nand_pkg: op encodings (OP_CMD/OP_ADDR/OP_WR/OP_RD), state enum, CE#-idle constant 8'hFF.
//  Sub-module nand_seq_timer: load value, count down, 1-cycle done pulse; shared by all phases.
// TESTING
//  CMD 8'hFF ce=0 last=1 -> cle=1, cen=8'hFE; WE# low 4 cycles after 3 setup; cen=8'hFF after hold.
//  CMD 8'h90, ADDR 8'h00, RD x4 (model drives 2C,DA,90,95) ce=2 -> rsp_data 2C,DA,90,95; CE# low throughout.
//  WR 8'hA5 -> wr_data_rise=wr_data_fall=A5, dq_oe_n=0 from SETUP to HOLD end, WE# pulse once.
//  req_valid held high across 3 ops -> exactly 3 accepts, gaps of 10 cycles, no dropped op.
//  rst0 asserted during PULSE of RD -> next cycle wen=1 wrn=1 cen=FF, rsp_valid never pulses.
//  wp_en toggled in PULSE -> ctrl_wpn follows 1 cycle later; debug bus 0 unless macro defined.

Source files
------------

// File: rtl/nand_async_seq_pkg.sv
// rtl/nand_async_seq_pkg.sv - op/state encodings and CE# helpers for the async NAND sequencer
package nand_async_seq_pkg;

  typedef enum logic [1:0] {
    OP_CMD  = 2'd0,
    OP_ADDR = 2'd1,
    OP_WR   = 2'd2,
    OP_RD   = 2'd3
  } nand_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  localparam logic [7:0] CEN_IDLE = 8'hFF;

  // Target index to active-low one-hot CE# vector.
  function automatic logic [7:0] ce_onehot_n(input logic [2:0] ce);
    return ~(8'h01 << ce);
  endfunction

endpackage

// File: rtl/nand_async_seq_timer.sv
// rtl/nand_async_seq_timer.sv - loadable down-counter with a one-cycle done pulse, shared by all phases
module nand_seq_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A phase loaded with N lasts exactly N cycles: done is high on its last cycle.
  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/nand_async_seq.sv
// rtl/nand_async_seq.sv - async SDR NAND pin sequencer; define NAND_ASYNC_SEQ_DEBUG_EN to drive ctrl_debug0
module nand_async_seq
  import nand_async_seq_pkg::*;
#(
  parameter int T_SETUP = 3,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int RD_LAT  = 3,
  parameter int CNT_W   = 4
) (
  input  logic        clk0,
  input  logic        rst0,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_data,
  input  logic [2:0]  req_ce,
  input  logic        req_last,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  input  logic        wp_en,
  output logic        ctrl_cle,
  output logic        ctrl_ale,
  output logic        ctrl_wrn,
  output logic        ctrl_wpn,
  output logic [7:0]  ctrl_cen,
  output logic        ctrl_wen,
  output logic        ctrl_wen_sel,
  output logic        dq_oe_n,
  output logic [7:0]  wr_data_rise,
  output logic [7:0]  wr_data_fall,
  input  logic [7:0]  rd_data_comb,
  output logic [15:0] ctrl_debug0
);

  // Timer value during PULSE at which the cycle ending RD_LAT cycles after RE# fell is running.
  localparam logic [CNT_W-1:0] RD_SAMPLE_CNT = CNT_W'(T_PULSE - RD_LAT + 1);

  seq_state_e       state, state_next;
  nand_op_e         op_q;
  logic             last_q;
  logic             accept;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val, tmr_cnt;
  logic             rd_sample;
  logic [7:0]       wr_data_q;

  logic       cle_d, ale_d, wen_d, wrn_d, oe_n_d, rsp_valid_d, ready_d, busy_d;
  logic [7:0] cen_d, wr_data_d, rsp_data_d;

  assign accept    = req_valid & req_ready;
  assign rd_sample = (state == ST_PULSE) && (op_q == OP_RD) && (tmr_cnt == RD_SAMPLE_CNT);

  nand_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk0),
    .rst      (rst0),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_cnt),
    .done     (tmr_done)
  );

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      op_q   <= OP_CMD;
      last_q <= 1'b0;
    end else if (accept) begin
      op_q   <= nand_op_e'(req_op);
      last_q <= req_last;
    end
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      ST_IDLE: if (accept) begin
        state_next = ST_SETUP;
        tmr_load   = 1'b1;
        tmr_val    = CNT_W'(T_SETUP);
      end
      ST_SETUP: if (tmr_done) begin
        state_next = ST_PULSE;
        tmr_load   = 1'b1;
        tmr_val    = CNT_W'(T_PULSE);
      end
      ST_PULSE: if (tmr_done) begin
        state_next = ST_HOLD;
        tmr_load   = 1'b1;
        tmr_val    = CNT_W'(T_HOLD);
      end
      ST_HOLD: if (tmr_done) begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered pins; everything holds unless a phase edge changes it.
  always_comb begin
    cle_d       = ctrl_cle;
    ale_d       = ctrl_ale;
    wen_d       = ctrl_wen;
    wrn_d       = ctrl_wrn;
    oe_n_d      = dq_oe_n;
    cen_d       = ctrl_cen;
    wr_data_d   = wr_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    case (state)
      ST_IDLE: if (accept) begin
        cen_d  = ce_onehot_n(req_ce);
        cle_d  = (req_op == OP_CMD);
        ale_d  = (req_op == OP_ADDR);
        oe_n_d = (req_op == OP_RD);
        if (req_op != OP_RD) wr_data_d = req_data;
      end
      ST_SETUP: if (tmr_done) begin
        if (op_q == OP_RD) wrn_d = 1'b0;
        else               wen_d = 1'b0;
      end
      ST_PULSE: begin
        if (rd_sample) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rd_data_comb;
        end
        if (tmr_done) begin
          wen_d = 1'b1;
          wrn_d = 1'b1;
        end
      end
      ST_HOLD: if (tmr_done) begin
        cle_d  = 1'b0;
        ale_d  = 1'b0;
        oe_n_d = 1'b1;
        if (last_q) cen_d = CEN_IDLE;
      end
      default: ;
    endcase
    ready_d = (state_next == ST_IDLE);
    busy_d  = (state_next != ST_IDLE) || (cen_d != CEN_IDLE);
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      ctrl_cle  <= 1'b0;
      ctrl_ale  <= 1'b0;
      ctrl_wen  <= 1'b1;
      ctrl_wrn  <= 1'b1;
      ctrl_wpn  <= 1'b1;
      ctrl_cen  <= CEN_IDLE;
      dq_oe_n   <= 1'b1;
      wr_data_q <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      req_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ctrl_cle  <= cle_d;
      ctrl_ale  <= ale_d;
      ctrl_wen  <= wen_d;
      ctrl_wrn  <= wrn_d;
      ctrl_wpn  <= ~wp_en;
      ctrl_cen  <= cen_d;
      dq_oe_n   <= oe_n_d;
      wr_data_q <= wr_data_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      req_ready <= ready_d;
      busy      <= busy_d;
    end
  end

  assign ctrl_wen_sel = 1'b1;
  assign wr_data_rise = wr_data_q;
  assign wr_data_fall = wr_data_q;

`ifdef NAND_ASYNC_SEQ_DEBUG_EN
  logic [7:0]  data_q;
  logic [15:0] debug_q;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      data_q  <= 8'h00;
      debug_q <= 16'h0000;
    end else begin
      if (accept) data_q <= req_data;
      debug_q <= {state, op_q, 4'(tmr_cnt), data_q};
    end
  end

  assign ctrl_debug0 = debug_q;
`else
  assign ctrl_debug0 = 16'h0000;
`endif

endmodule
